instruction_fetch: RTL and testbench

//  Consumer end of the program counter: reads pc_po, fetches instructions from instruction memory

---
 rtl/instruction_fetch.sv | 164 ++++++++++++++++
 tb/tb_instruction_fetch.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// Instruction fetch: pulls instructions at pc_pi over imem req/ack into a prefetch FIFO.
// Define FETCH_PERF_EN to build the stall/flush performance counters.
module instruction_fetch #(
    parameter int DEPTH = 4
) (
    input  logic        clk_pi,
    input  logic        reset_pi,
    input  logic        clk_en_pi,
    input  logic [15:0] pc_pi,
    input  logic        redirect_pi,
    output logic        pc_advance_po,
    output logic        imem_req_po,
    output logic [15:0] imem_addr_po,
    input  logic        imem_ack_pi,
    input  logic [15:0] imem_data_pi,
    output logic        instr_valid_po,
    output logic [15:0] instr_po,
    output logic [15:0] instr_pc_po,
    input  logic        decode_ready_pi,
    output logic [15:0] perf_stall_cnt_po,
    output logic [15:0] perf_flush_cnt_po
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DISCARD
    } state_t;

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] instr;
    } entry_t;

    state_t        state_q, state_d;
    logic          req_q, req_d;
    logic [15:0]   addr_q, addr_d;
    entry_t        fifo_q [DEPTH];
    logic [PW-1:0] wr_q, rd_q;
    logic [PW:0]   cnt_q, cnt_d;
    logic [PW:0]   cnt_after_push;
    logic          push, pop;

    assign instr_valid_po = (cnt_q != '0);
    assign instr_po       = fifo_q[rd_q].instr;
    assign instr_pc_po    = fifo_q[rd_q].pc;
    assign imem_req_po    = req_q;
    assign imem_addr_po   = addr_q;

    assign pop = clk_en_pi & instr_valid_po & decode_ready_pi & ~redirect_pi;

    // Occupancy as it will be after this edge if the pending ack is pushed
    assign cnt_after_push = cnt_q + (PW+1)'(1) - (PW+1)'(pop);

    always_comb begin
        state_d       = state_q;
        req_d         = req_q;
        addr_d        = addr_q;
        push          = 1'b0;
        pc_advance_po = 1'b0;
        if (clk_en_pi) begin
            unique case (state_q)
                IDLE: begin
                    if (!redirect_pi && cnt_q < FULL) begin
                        req_d   = 1'b1;
                        addr_d  = pc_pi;
                        state_d = REQ;
                    end
                end
                REQ: begin
                    if (redirect_pi) begin
                        if (imem_ack_pi) begin
                            req_d   = 1'b0;
                            state_d = IDLE;
                        end else begin
                            state_d = DISCARD;
                        end
                    end else if (imem_ack_pi) begin
                        push          = 1'b1;
                        pc_advance_po = 1'b1;
                        if (cnt_after_push < FULL) begin
                            addr_d = addr_q + 16'd2;
                        end else begin
                            req_d   = 1'b0;
                            state_d = IDLE;
                        end
                    end
                end
                DISCARD: begin
                    if (imem_ack_pi) begin
                        req_d   = 1'b0;
                        state_d = IDLE;
                    end
                end
                default: begin
                    req_d   = 1'b0;
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        unique case (1'b1)
            redirect_pi:   cnt_d = '0;
            push && !pop:  cnt_d = cnt_q + (PW+1)'(1);
            !push && pop:  cnt_d = cnt_q - (PW+1)'(1);
            default:       cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_pi) begin
        if (reset_pi) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            addr_q  <= 16'h0000;
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
        end else if (clk_en_pi) begin
            state_q <= state_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            if (redirect_pi) begin
                wr_q <= '0;
                rd_q <= '0;
            end else begin
                if (push) wr_q <= wr_q + PW'(1);
                if (pop)  rd_q <= rd_q + PW'(1);
            end
        end
    end

    // Entry storage needs no reset; occupancy gates visibility
    always_ff @(posedge clk_pi) begin
        if (push) fifo_q[wr_q] <= '{pc: addr_q, instr: imem_data_pi};
    end

`ifdef FETCH_PERF_EN
    logic [15:0] stall_q, flush_q;

    always_ff @(posedge clk_pi) begin
        if (reset_pi) begin
            stall_q <= 16'h0000;
            flush_q <= 16'h0000;
        end else if (clk_en_pi) begin
            if (!instr_valid_po && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
            if (redirect_pi && flush_q != 16'hFFFF)     flush_q <= flush_q + 16'd1;
        end
    end

    assign perf_stall_cnt_po = stall_q;
    assign perf_flush_cnt_po = flush_q;
`else
    assign perf_stall_cnt_po = 16'h0000;
    assign perf_flush_cnt_po = 16'h0000;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: PC and memory models plus an in-order
// scoreboard of expected {pc, instr} deliveries to decode.
module tb_instruction_fetch;

    logic        clk;
    logic        reset;
    logic        clk_en;
    logic [15:0] pc;
    logic        redirect;
    logic        advance;
    logic        req;
    logic [15:0] addr;
    logic        ack;
    logic [15:0] data;
    logic        valid;
    logic [15:0] instr;
    logic [15:0] ipc;
    logic        ready;
    logic [15:0] stall;
    logic [15:0] flush;

    logic        pc_load;
    logic [15:0] pc_load_val;
    logic [15:0] target;
    logic        mem_en;
    logic        stray_ack;
    int          lat;
    int          wait_cnt = 0;

    int          n_checks = 0;
    int          n_pass = 0;
    int          n_fail = 0;
    logic [15:0] sb_q[$];

    instruction_fetch #(.DEPTH(4)) dut (
        .clk_pi            (clk),
        .reset_pi          (reset),
        .clk_en_pi         (clk_en),
        .pc_pi             (pc),
        .redirect_pi       (redirect),
        .pc_advance_po     (advance),
        .imem_req_po       (req),
        .imem_addr_po      (addr),
        .imem_ack_pi       (ack),
        .imem_data_pi      (data),
        .instr_valid_po    (valid),
        .instr_po          (instr),
        .instr_pc_po       (ipc),
        .decode_ready_pi   (ready),
        .perf_stall_cnt_po (stall),
        .perf_flush_cnt_po (flush)
    );

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return 16'hBEEF ^ {a[7:0], a[15:8]};
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory: acks after `lat` waiting cycles, only while clk_en is high
    assign data = mem_word(addr);
    assign ack  = clk_en & ((mem_en & req & (wait_cnt >= lat)) | stray_ack);

    always @(posedge clk) begin
        if (clk_en) begin
            if (!mem_en || !req || ack) wait_cnt <= 0;
            else wait_cnt <= wait_cnt + 1;
        end
    end

    // Program counter model
    always @(posedge clk) begin
        if (pc_load) pc <= pc_load_val;
        else if (clk_en) begin
            if (redirect) pc <= target;
            else if (advance) pc <= pc + 16'd2;
        end
    end

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic got, input logic exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // Advance one cycle; the scoreboard checks any pop the coming edge performs
    task automatic tick();
        logic [15:0] e;
        @(negedge clk);
        if (!reset && clk_en && valid === 1'b1 && ready && !redirect) begin
            n_checks++;
            assert (sb_q.size() != 0) n_pass++;
            else begin
                n_fail++;
                $error("FAIL sb_extra: got pc %h expected no delivery", ipc);
            end
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                chk("sb_pc", ipc, e);
                chk("sb_instr", instr, mem_word(e));
            end
        end
        @(posedge clk);
        #2;
    endtask

    task automatic drain(input string tag);
        int k = 0;
        while (sb_q.size() != 0 && k < 12) begin
            tick();
            k++;
        end
        chk(tag, 16'(sb_q.size()), 16'd0);
    endtask

    task automatic wait_ack(input string tag);
        int k = 0;
        while (ack !== 1'b1 && k < 10) begin
            tick();
            k++;
        end
        chkb(tag, ack, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] wrap_a [3];
        wrap_a = '{16'hFFFC, 16'hFFFE, 16'h0000};
        reset = 1'b1; clk_en = 1'b1; redirect = 1'b0; target = 16'h0000;
        ready = 1'b1; pc_load = 1'b1; pc_load_val = 16'h0000;
        mem_en = 1'b1; stray_ack = 1'b0; lat = 0;
        tick();
        tick();
        chkb("rst_req", req, 1'b0);
        chk("rst_addr", addr, 16'h0000);
        chkb("rst_valid", valid, 1'b0);
        chk("rst_stall", stall, 16'h0000);
        chk("rst_flush", flush, 16'h0000);

        // 1: zero-wait streaming
        reset = 1'b0; pc_load = 1'b0;
        for (int i = 0; i < 6; i++) sb_q.push_back(16'(2 * i));
        tick();
        for (int i = 0; i < 6; i++) begin
            chkb("t1_req", req, 1'b1);
            chk("t1_addr", addr, 16'(2 * i));
            chkb("t1_adv", advance, 1'b1);
            tick();
        end
        mem_en = 1'b0;
        drain("t1_drain");
        chkb("t1_empty", valid, 1'b0);
        chk("t1_hold_addr", addr, 16'h000C);

        // 2: fill with decode stalled, then release
        ready = 1'b0; mem_en = 1'b1;
        for (int i = 0; i < 4; i++) sb_q.push_back(16'(12 + 2 * i));
        #1;
        for (int i = 0; i < 4; i++) begin
            chkb("t2_adv", advance, 1'b1);
            chk("t2_addr", addr, 16'(12 + 2 * i));
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            chkb("t2_full_req", req, 1'b0);
            chkb("t2_full_adv", advance, 1'b0);
            chkb("t2_full_valid", valid, 1'b1);
            chk("t2_full_head", ipc, 16'h000C);
            tick();
        end
        ready = 1'b1; mem_en = 1'b0;
        drain("t2_drain");
        chkb("t2_resume_req", req, 1'b1);
        chk("t2_resume_addr", addr, 16'h0014);

        // 3: redirect while a 2-cycle request is pending
        redirect = 1'b1; target = 16'h0040; mem_en = 1'b1; lat = 2;
        #1;
        chkb("t3_redir_adv", advance, 1'b0);
        tick();
        redirect = 1'b0;
        #1;
        chkb("t3_flushed", valid, 1'b0);
        chkb("t3_disc_req", req, 1'b1);
        chk("t3_disc_addr", addr, 16'h0014);
        wait_ack("t3_late_ack");
        chkb("t3_late_adv", advance, 1'b0);
        tick();
        chkb("t3_idle_req", req, 1'b0);
        chkb("t3_idle_valid", valid, 1'b0);
        tick();
        chkb("t3_new_req", req, 1'b1);
        chk("t3_new_addr", addr, 16'h0040);

        // 4: redirect coincident with ack flushes a held entry
        ready = 1'b0;
        wait_ack("t4_ack0");
        chkb("t4_adv0", advance, 1'b1);
        tick();
        chkb("t4_valid", valid, 1'b1);
        chk("t4_head", ipc, 16'h0040);
        chk("t4_instr", instr, mem_word(16'h0040));
        wait_ack("t4_ack1");
        chk("t4_addr1", addr, 16'h0042);
        redirect = 1'b1; target = 16'h0080;
        #1;
        chkb("t4_redir_adv", advance, 1'b0);
        tick();
        redirect = 1'b0;
        #1;
        chkb("t4_flushed", valid, 1'b0);
        chkb("t4_idle_req", req, 1'b0);
`ifdef FETCH_PERF_EN
        chk("perf_flush", flush, 16'd2);
        chkb("perf_stall_nz", stall != 16'h0000, 1'b1);
`else
        chk("perf_flush", flush, 16'h0000);
        chk("perf_stall", stall, 16'h0000);
`endif

        // 5: address wrap with back-to-back acks
        reset = 1'b1; pc_load = 1'b1; pc_load_val = 16'hFFFC;
        lat = 0; mem_en = 1'b1; ready = 1'b1;
        tick();
        tick();
        reset = 1'b0; pc_load = 1'b0;
        for (int i = 0; i < 3; i++) sb_q.push_back(wrap_a[i]);
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("t5_addr", addr, wrap_a[i]);
            chkb("t5_adv", advance, 1'b1);
            tick();
        end
        chk("t5_next_addr", addr, 16'h0002);

        // 6: freeze mid-request, then reset mid-request
        ready = 1'b0; lat = 2;
        sb_q.push_back(16'h0002);
        #1;
        wait_ack("t6_ack");
        chkb("t6_adv", advance, 1'b1);
        tick();
        clk_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chkb("t6_frz_req", req, 1'b1);
            chk("t6_frz_addr", addr, 16'h0004);
            chkb("t6_frz_valid", valid, 1'b1);
            chk("t6_frz_head", ipc, 16'h0000);
            chk("t6_frz_instr", instr, mem_word(16'h0000));
            chkb("t6_frz_adv", advance, 1'b0);
        end
        clk_en = 1'b1; ready = 1'b1; mem_en = 1'b0;
        drain("t6_drain");
        chkb("t6_pre_rst_req", req, 1'b1);
        reset = 1'b1; pc_load = 1'b1; pc_load_val = 16'h0100;
        mem_en = 1'b1; lat = 0;
        tick();
        chkb("t6_rst_req", req, 1'b0);
        chk("t6_rst_addr", addr, 16'h0000);
        chkb("t6_rst_valid", valid, 1'b0);
        chk("t6_rst_stall", stall, 16'h0000);
        chk("t6_rst_flush", flush, 16'h0000);
        reset = 1'b0; pc_load = 1'b0; mem_en = 1'b0; stray_ack = 1'b1;
        #1;
        chkb("t6_stray_adv", advance, 1'b0);
        tick();
        stray_ack = 1'b0;
        #1;
        chkb("t6_stray_valid", valid, 1'b0);
        chkb("t6_new_req", req, 1'b1);
        chk("t6_new_addr", addr, 16'h0100);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
